except_ctrl: RTL and testbench
==============================

# except_ctrl

Exception controller at the MEM/WB boundary and the producer side of the CP0 exception interface. Collects per-instruction exception flags and the sampled interrupt condition, then selects the highest-priority cause. Issues a one-cycle registered commit (`except_type_o`, `pc_o`, `is_in_delayslot_o`, `mem_addr_o`) to CP0, consumes CP0's combinational `exception_vector`, and drives pipeline flush plus PC redirect.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 1: cycles spent in DRAIN after a commit, range 1–3.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `valid_i` input 1: a MEM-stage instruction is present.
- `mem_stall_i` input 1: MEM stage stalled by memory.
- `pc_i` input 32: PC of the MEM instruction.
- `is_in_delayslot_i` input 1: the MEM instruction is in a delay slot.
- `mem_addr_i` input 32: data address of the MEM instruction.
- `exc_flags_i` input 9: bit order {eret, ades, adel_d, break, syscall, ov, trap, ri, adel_f}, bit 0 = adel_f.
- `status_i` input 32: CP0 Status.
- `cause_i` input 32: CP0 Cause.
- `exception_vector_i` input 32: CP0 vector, combinational from `except_type_o`.
- `except_type_o` output 32: exception code sent to CP0; 0 means none.
- `pc_o` output 32: registered PC of the excepting instruction.
- `is_in_delayslot_o` output 1: registered delay-slot flag.
- `mem_addr_o` output 32: registered data address.
- `mem_kill_o` output 1: combinational; suppress the current memory access.
- `flush_o` output 1: flush IF through MEM.
- `new_pc_o` output 32: redirect target.
- `new_pc_valid_o` output 1: redirect strobe.

## Operation
- Codes: INT=0x1, ADEL_F=0xf, RI=0xa, TRAP=0xd, OV=0xc, SYSCALL=0x8, BREAK=0x9, ADEL_D=0x4, ADES=0x5, ERET=0xe.
- Priority, highest first: INT, ADEL_F, RI, SYSCALL, BREAK, OV, TRAP, ADEL_D, ADES, ERET.
- Interrupt condition `int_cond` = Status.IE & ~Status.EXL & ~Status.ERL & |(Cause[15:8] & Status[15:8]).
- `int_pend_q` <= `int_cond` every cycle.
- An interrupt is taken only when `int_pend_q` & `int_cond`, which gives a 2-cycle qualification and rejects a 1-cycle glitch.
- Detection fires when state is IDLE & `valid_i` & the selected code ≠ 0.
- Stall gating:
  - Any code except ADEL_D/ADES also requires ~`mem_stall_i`.
  - ADEL_D/ADES ignore `mem_stall_i`; that access is killed and never starts.
- `mem_kill_o` = IDLE & `valid_i` & (any flag set or interrupt taken).
- FSM states:
  - IDLE → COMMIT on detection. Latch code, `pc_i`, `is_in_delayslot_i`, `mem_addr_i` into the output registers.
  - COMMIT, exactly 1 cycle: `except_type_o` holds the code; `flush_o`=1; `new_pc_o`=`exception_vector_i`; `new_pc_valid_o`=1. Go to DRAIN.
  - DRAIN, `DRAIN_CYCLES` cycles: `except_type_o`=0, `flush_o`=1, `new_pc_valid_o`=0. All inputs are ignored. Then go to IDLE.
- Interrupt together with eret on the same instruction: INT wins, eret is not performed, `pc_o` = eret PC.
- The delay-slot PC adjustment is performed by CP0; this block passes `pc_i` unmodified.

## Timing
- Reset values: all outputs 0, state IDLE, `int_pend_q`=0. Assertion takes effect immediately (async) from any state. After deassertion the block starts in IDLE with no pending commit.
- Detection in cycle N → `except_type_o`/`flush_o`/`new_pc_valid_o` high in cycle N+1. CP0 updates at the end of N+1. `new_pc_o` is valid during N+1 only.
- `except_type_o` is nonzero in COMMIT only, so every exception is presented to CP0 for exactly one cycle.
- Back-to-back exceptions: the minimum spacing between commits is 2+`DRAIN_CYCLES` cycles.
- Interrupt latency: `int_cond` rising in cycle N → earliest commit in cycle N+2, provided a valid unstalled instruction is present in N+1.

## Structure
- Exception code constants and the `exc_flags_i` bit indices go in shared `define.vh`, next to the `CP0_REG_*` macros.
- FSM state enum is local to the module.
- One combinational sub-module, `except_prio`: flags + `int_take` → 32-bit code.

## Test plan
- Reset: `rst`=0 with random inputs → all outputs 0. Release, no flags → `except_type_o` stays 0.
- Syscall: `pc_i`=0x80001000, ~stall → next cycle `except_type_o`=0x8, `pc_o`=0x80001000, `flush_o`=1, `new_pc_o`=vector (0x80000180 BEV=0). Then 1 DRAIN cycle with `flush_o`=1, `except_type_o`=0.
- Priority: ri+ov+ades set together → code 0xa; `mem_kill_o`=1 in the detection cycle.
- Stall: ades with `mem_stall_i`=1 → commits next cycle with code 0x5. Syscall with stall held 3 cycles → commits 1 cycle after stall drops.
- Interrupt: IE=1, IM2=1, IP2 pulse 1 cycle → no commit. IP2 held → code 0x1; eret on the same instruction is ignored.
- Eret with `exception_vector_i`=EPC=0x80002004 → `new_pc_o`=0x80002004. `rst` asserted during DRAIN → outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/except_ctrl_pkg.sv
// Shared constants for the exception controller: CP0 exception codes,
// exc_flags bit positions, Status bit positions and the priority table.
package except_ctrl_pkg;

  // Exception codes presented to CP0 (0 means no exception)
  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_ADEL_D  = 32'h4;
  localparam logic [31:0] EXC_ADES    = 32'h5;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_BREAK   = 32'h9;
  localparam logic [31:0] EXC_RI      = 32'ha;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_ERET    = 32'he;
  localparam logic [31:0] EXC_ADEL_F  = 32'hf;

  // Bit positions inside exc_flags_i
  localparam int FLAG_W       = 9;
  localparam int FLAG_ADEL_F  = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_TRAP    = 2;
  localparam int FLAG_OV      = 3;
  localparam int FLAG_SYSCALL = 4;
  localparam int FLAG_BREAK   = 5;
  localparam int FLAG_ADEL_D  = 6;
  localparam int FLAG_ADES    = 7;
  localparam int FLAG_ERET    = 8;

  // Status register fields used for interrupt qualification
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;

  // Number of entries in the priority-ordered request vector (index 0 wins)
  localparam int PRIO_N = 10;

  // Code associated with each slot of the priority-ordered request vector
  function automatic logic [31:0] prio_code(input int idx);
    logic [31:0] code;
    case (idx)
      0:       code = EXC_INT;
      1:       code = EXC_ADEL_F;
      2:       code = EXC_RI;
      3:       code = EXC_SYSCALL;
      4:       code = EXC_BREAK;
      5:       code = EXC_OV;
      6:       code = EXC_TRAP;
      7:       code = EXC_ADEL_D;
      8:       code = EXC_ADES;
      9:       code = EXC_ERET;
      default: code = EXC_NONE;
    endcase
    return code;
  endfunction

  // Data-access faults are raised before the access starts, so they do not
  // wait for the memory stall to clear
  function automatic logic is_mem_code(input logic [31:0] code);
    return (code == EXC_ADEL_D) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/except_ctrl_prio.sv
// Combinational priority selector: per-instruction flags plus the qualified
// interrupt request are reduced to the single highest-priority cause code.
module except_prio
  import except_ctrl_pkg::*;
(
  input  logic [FLAG_W-1:0] exc_flags_i,
  input  logic              int_take_i,
  output logic [31:0]       code_o
);

  logic [PRIO_N-1:0] req;
  logic [PRIO_N-1:0] grant;
  logic [31:0]       masked [PRIO_N];

  // Requests reordered so that index 0 is the highest priority
  assign req = {
    exc_flags_i[FLAG_ERET],
    exc_flags_i[FLAG_ADES],
    exc_flags_i[FLAG_ADEL_D],
    exc_flags_i[FLAG_TRAP],
    exc_flags_i[FLAG_OV],
    exc_flags_i[FLAG_BREAK],
    exc_flags_i[FLAG_SYSCALL],
    exc_flags_i[FLAG_RI],
    exc_flags_i[FLAG_ADEL_F],
    int_take_i
  };

  // One-hot grant: a slot wins only if no higher-priority slot requests
  genvar gi;
  generate
    for (gi = 0; gi < PRIO_N; gi++) begin : g_grant
      if (gi == 0) begin : g_top
        assign grant[gi] = req[gi];
      end else begin : g_rest
        assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
      end
      assign masked[gi] = grant[gi] ? prio_code(gi) : EXC_NONE;
    end
  endgenerate

  // Grant is one-hot, so OR-ing the masked codes yields the winner's code
  always_comb begin
    code_o = EXC_NONE;
    for (int i = 0; i < PRIO_N; i++) begin
      code_o = code_o | masked[i];
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// Exception controller at the MEM/WB boundary. Selects the highest-priority
// cause, presents it to CP0 for exactly one cycle, then flushes the pipeline
// and redirects fetch to the CP0-supplied vector.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              mem_stall_i,
  input  logic [31:0]       pc_i,
  input  logic              is_in_delayslot_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [FLAG_W-1:0] exc_flags_i,
  input  logic [31:0]       status_i,
  input  logic [31:0]       cause_i,
  input  logic [31:0]       exception_vector_i,
  output logic [31:0]       except_type_o,
  output logic [31:0]       pc_o,
  output logic              is_in_delayslot_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_kill_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              new_pc_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [1:0]  drain_cnt_reg, drain_cnt_next;

  logic        int_cond;
  logic        int_pend_reg;
  logic        int_take;
  logic [31:0] sel_code;
  logic        detect;

  logic [31:0] code_reg;
  logic [31:0] pc_reg;
  logic [31:0] addr_reg;
  logic        ds_reg;

  // Status/Cause bits that play no part in interrupt qualification
  logic        unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:3], cause_i[31:16], cause_i[7:0]};

  // Interrupt is enabled, not masked by EXL/ERL, and some unmasked line pends
  assign int_cond = status_i[ST_IE] & ~status_i[ST_EXL] & ~status_i[ST_ERL]
                  & (|(cause_i[15:8] & status_i[15:8]));

  // A one-cycle pulse on the interrupt lines must not be taken, so the
  // condition has to be seen on two consecutive cycles
  assign int_take = int_pend_reg & int_cond;

  except_prio u_prio (
    .exc_flags_i (exc_flags_i),
    .int_take_i  (int_take),
    .code_o      (sel_code)
  );

  // Stalled instructions wait, except data-access faults which kill the access
  assign detect = (state_reg == ST_IDLE) & valid_i & (sel_code != EXC_NONE)
                & (is_mem_code(sel_code) | ~mem_stall_i);

  // Kill the memory access of any instruction that carries a fault or is
  // about to be interrupted; nothing is killed while reset is held
  assign mem_kill_o = rst & (state_reg == ST_IDLE) & valid_i
                    & ((|exc_flags_i) | int_take);

  // Sample the interrupt condition every cycle for two-cycle qualification
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_pend_reg <= 1'b0;
    end else begin
      int_pend_reg <= int_cond;
    end
  end

  // FSM state register and drain counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // FSM next-state logic: IDLE -> COMMIT (1 cycle) -> DRAIN (DRAIN_CYCLES) -> IDLE
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (detect) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_next     = ST_DRAIN;
        drain_cnt_next = DRAIN_LAST;
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == 2'd0) begin
          state_next = ST_IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg - 2'd1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        drain_cnt_next = 2'd0;
      end
    endcase
  end

  // Capture the excepting instruction's code, PC, delay-slot flag and address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_reg <= EXC_NONE;
      pc_reg   <= 32'h0;
      addr_reg <= 32'h0;
      ds_reg   <= 1'b0;
    end else if (detect) begin
      code_reg <= sel_code;
      pc_reg   <= pc_i;
      addr_reg <= mem_addr_i;
      ds_reg   <= is_in_delayslot_i;
    end
  end

  // FSM outputs: code and redirect only in COMMIT, flush in COMMIT and DRAIN
  always_comb begin
    except_type_o  = EXC_NONE;
    flush_o        = 1'b0;
    new_pc_o       = 32'h0;
    new_pc_valid_o = 1'b0;
    case (state_reg)
      ST_COMMIT: begin
        except_type_o  = code_reg;
        flush_o        = 1'b1;
        new_pc_o       = exception_vector_i;
        new_pc_valid_o = 1'b1;
      end
      ST_DRAIN: begin
        flush_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pc_o              = pc_reg;
  assign mem_addr_o        = addr_reg;
  assign is_in_delayslot_o = ds_reg;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed testbench for except_ctrl with a tiny combinational CP0 vector model.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        mem_stall = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        ds = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [8:0]  flags = 9'h0;
  logic [31:0] status = 32'h0;
  logic [31:0] cause = 32'h0;
  logic [31:0] exception_vector;
  logic [31:0] except_type;
  logic [31:0] pc_q;
  logic        ds_q;
  logic [31:0] mem_addr_q;
  logic        mem_kill;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;

  logic [31:0] epc = 32'h0;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] F_RI      = 9'h002;
  localparam logic [8:0] F_OV      = 9'h008;
  localparam logic [8:0] F_SYSCALL = 9'h010;
  localparam logic [8:0] F_ADES    = 9'h080;
  localparam logic [8:0] F_ERET    = 9'h100;
  localparam logic [31:0] VEC_GEN  = 32'h80000180;

  always #5 clk = ~clk;

  // CP0 model: eret returns to EPC, everything else to the general vector
  assign exception_vector = (except_type == 32'he) ? epc :
                            (except_type != 32'h0) ? VEC_GEN : 32'h0;

  except_ctrl #(.DRAIN_CYCLES(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_i            (valid),
    .mem_stall_i        (mem_stall),
    .pc_i               (pc),
    .is_in_delayslot_i  (ds),
    .mem_addr_i         (mem_addr),
    .exc_flags_i        (flags),
    .status_i           (status),
    .cause_i            (cause),
    .exception_vector_i (exception_vector),
    .except_type_o      (except_type),
    .pc_o               (pc_q),
    .is_in_delayslot_o  (ds_q),
    .mem_addr_o         (mem_addr_q),
    .mem_kill_o         (mem_kill),
    .flush_o            (flush),
    .new_pc_o           (new_pc),
    .new_pc_valid_o     (new_pc_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("check %s: 0x%08h ok", tag, got);
    end
  endtask

  // Advance one clock; return at the falling edge so outputs are stable
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid     = 1'b0;
    mem_stall = 1'b0;
    flags     = 9'h0;
  endtask

  initial begin
    // Reset with random inputs
    @(negedge clk);
    valid     = 1'b1;
    mem_stall = 1'($urandom);
    pc        = $urandom;
    ds        = 1'($urandom);
    mem_addr  = $urandom;
    flags     = 9'($urandom);
    status    = $urandom;
    cause     = $urandom;
    tick();
    check("rst except_type", except_type, 32'h0);
    check("rst pc_o", pc_q, 32'h0);
    check("rst mem_addr_o", mem_addr_q, 32'h0);
    check("rst ds_o", 32'(ds_q), 32'h0);
    check("rst flush", 32'(flush), 32'h0);
    check("rst new_pc_valid", 32'(new_pc_valid), 32'h0);
    check("rst new_pc", new_pc, 32'h0);
    check("rst mem_kill", 32'(mem_kill), 32'h0);
    idle_inputs();
    status = 32'h0;
    cause  = 32'h0;
    rst    = 1'b1;
    tick();
    tick();
    check("idle except_type", except_type, 32'h0);
    check("idle flush", 32'(flush), 32'h0);

    // Syscall, unstalled
    valid = 1'b1; pc = 32'h80001000; mem_addr = 32'h00001234; ds = 1'b1; flags = F_SYSCALL;
    #1 check("sys mem_kill", 32'(mem_kill), 32'h1);
    tick();
    check("sys except_type", except_type, 32'h8);
    check("sys pc_o", pc_q, 32'h80001000);
    check("sys ds_o", 32'(ds_q), 32'h1);
    check("sys mem_addr_o", mem_addr_q, 32'h00001234);
    check("sys flush", 32'(flush), 32'h1);
    check("sys new_pc", new_pc, VEC_GEN);
    check("sys new_pc_valid", 32'(new_pc_valid), 32'h1);
    idle_inputs(); ds = 1'b0;
    tick();
    check("sys drain flush", 32'(flush), 32'h1);
    check("sys drain except_type", except_type, 32'h0);
    check("sys drain new_pc_valid", 32'(new_pc_valid), 32'h0);
    tick();
    check("sys idle flush", 32'(flush), 32'h0);

    // Priority: ri + ov + ades -> RI
    valid = 1'b1; pc = 32'h80001100; flags = F_RI | F_OV | F_ADES;
    #1 check("prio mem_kill", 32'(mem_kill), 32'h1);
    tick();
    check("prio except_type", except_type, 32'ha);
    idle_inputs();
    tick();
    tick();

    // ades while stalled commits immediately
    valid = 1'b1; pc = 32'h80001200; mem_stall = 1'b1; flags = F_ADES;
    #1 check("ades mem_kill", 32'(mem_kill), 32'h1);
    tick();
    check("ades except_type", except_type, 32'h5);
    check("ades pc_o", pc_q, 32'h80001200);
    idle_inputs();
    tick();
    tick();

    // Syscall held off by a 3-cycle stall
    valid = 1'b1; pc = 32'h80001300; mem_stall = 1'b1; flags = F_SYSCALL;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d except_type", i), except_type, 32'h0);
    end
    mem_stall = 1'b0;
    tick();
    check("stall commit except_type", except_type, 32'h8);
    check("stall commit pc_o", pc_q, 32'h80001300);
    idle_inputs();
    tick();
    tick();

    // One-cycle IP2 glitch is rejected
    status = 32'h00000401; valid = 1'b1; pc = 32'h80001400; flags = 9'h0;
    cause = 32'h00000400;
    #1 check("glitch mem_kill", 32'(mem_kill), 32'h0);
    tick();
    cause = 32'h0;
    tick();
    check("glitch except_type a", except_type, 32'h0);
    tick();
    check("glitch except_type b", except_type, 32'h0);

    // IP2 held: interrupt beats eret on the same instruction
    valid = 1'b0;
    cause = 32'h00000400;
    tick();
    valid = 1'b1; pc = 32'h80003000; flags = F_ERET; epc = 32'h80002004;
    #1 check("int mem_kill", 32'(mem_kill), 32'h1);
    tick();
    check("int except_type", except_type, 32'h1);
    check("int pc_o", pc_q, 32'h80003000);
    check("int new_pc", new_pc, VEC_GEN);
    idle_inputs();
    cause = 32'h0; status = 32'h0;
    tick();
    tick();

    // Eret redirects to EPC; reset during DRAIN clears outputs at once
    valid = 1'b1; pc = 32'h80002000; flags = F_ERET;
    tick();
    check("eret except_type", except_type, 32'he);
    check("eret new_pc", new_pc, 32'h80002004);
    check("eret new_pc_valid", 32'(new_pc_valid), 32'h1);
    idle_inputs();
    tick();
    check("eret drain flush", 32'(flush), 32'h1);
    #1 rst = 1'b0;
    #1 check("async rst flush", 32'(flush), 32'h0);
    check("async rst pc_o", pc_q, 32'h0);
    check("async rst except_type", except_type, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post rst flush", 32'(flush), 32'h0);

    // Back-to-back syscalls: commits 3 cycles apart with DRAIN_CYCLES=1
    valid = 1'b1; pc = 32'h80004000; flags = F_SYSCALL;
    tick();
    check("b2b c0", except_type, 32'h8);
    tick();
    check("b2b drain", except_type, 32'h0);
    tick();
    check("b2b idle", except_type, 32'h0);
    check("b2b idle flush", 32'(flush), 32'h0);
    tick();
    check("b2b c1", except_type, 32'h8);
    idle_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
